// File: rtl/nand_ctrl_pkg.sv
// nand_ctrl_pkg: register map, AHB encodings and FSM states for the NAND command master
package nand_ctrl_pkg;
    localparam logic [7:0] OFS_TIMING = 8'h00;
    localparam logic [7:0] OFS_COL    = 8'h04;
    localparam logic [7:0] OFS_ROW    = 8'h08;
    localparam logic [7:0] OFS_CFG    = 8'h0C;
    localparam logic [7:0] OFS_CMD    = 8'h10;
    localparam logic [7:0] OFS_ID0    = 8'h14;
    localparam logic [7:0] OFS_ID1    = 8'h18;
    localparam logic [7:0] OFS_MFSM   = 8'h1C;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    typedef enum logic [3:0] {
        S_IDLE, S_WR_TIM, S_WR_COL, S_WR_ROW, S_WR_CFG, S_WR_CMD,
        S_WAIT_DONE, S_RD_STAT, S_RD_ID0, S_RD_ID1, S_RESP
    } state_t;
    typedef enum logic [1:0] {X_IDLE, X_ADDR, X_DATA} xfer_state_t;
endpackage

// File: rtl/nand_cmd_master_if.sv
// nand_cmd_master_if: AHB-Lite initiator/target signal bundle
interface nand_cmd_master_if;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    modport master (output haddr, htrans, hwrite, hsize, hwdata, input hrdata, hready);
    modport slave  (input haddr, htrans, hwrite, hsize, hwdata, output hrdata, hready);
endinterface

// File: rtl/ahb_single_xfer.sv
// ahb_single_xfer: one non-pipelined AHB-Lite transfer (address phase then data phase)
module ahb_single_xfer
    import nand_ctrl_pkg::*;
(
    input  logic               hclk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        addr,
    input  logic               write,
    input  logic [31:0]        wdata,
    output logic               busy,
    output logic [31:0]        rdata,
    output logic               xfer_done,
    nand_cmd_master_if.master  bus
);
    xfer_state_t state, state_nx;
    logic [31:0] addr_q, wdata_q;
    logic        write_q;

    always_ff @(posedge hclk) begin
        if (rst) begin
            state   <= X_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (start && state == X_IDLE) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                write_q <= write;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            X_IDLE:  state_nx = start ? X_ADDR : X_IDLE;
            X_ADDR:  state_nx = bus.hready ? X_DATA : X_ADDR;
            X_DATA:  state_nx = bus.hready ? X_IDLE : X_DATA;
            default: state_nx = X_IDLE;
        endcase
    end

    assign busy       = state != X_IDLE;
    assign xfer_done  = state == X_DATA && bus.hready;
    assign rdata      = bus.hrdata;
    assign bus.haddr  = addr_q;
    assign bus.htrans = state == X_ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.hwrite = state == X_ADDR && write_q;
    assign bus.hsize  = HSIZE_WORD;
    assign bus.hwdata = wdata_q;
endmodule

// File: rtl/nand_cmd_master.sv
// nand_cmd_master: programs the NAND controller register file for one flash operation over AHB-Lite
module nand_cmd_master
    import nand_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0500,
    parameter logic [15:0] CMD_READ_ID = 16'h0090,
    parameter int          TO_W        = 16
) (
    input  logic               hclk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_timing,
    input  logic [15:0]        req_col,
    input  logic [23:0]        req_row,
    input  logic [2:0]         req_cfg,
    input  logic [15:0]        req_cmd,
    nand_cmd_master_if.master  bus,
    input  logic               done_i,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [7:0]         rsp_status,
    output logic [47:0]        rsp_id,
    output logic               rsp_timeout
);
    state_t state, state_nx;
    logic [31:0] timing_q, wdata, rdata;
    logic [15:0] col_q, cmd_q;
    logic [23:0] row_q;
    logic [2:0]  cfg_q;
    logic [7:0]  ofs;
    logic [TO_W-1:0] to_cnt;
    logic done_q, done_rise, to_hit, xfer_state, xfer_write, start, busy, xfer_done;

    assign done_rise = done_i && !done_q;
    assign to_hit    = &to_cnt;
    assign req_ready = state == S_IDLE;
    assign rsp_valid = state == S_RESP;
    assign start     = xfer_state && !busy;

    ahb_single_xfer u_xfer (
        .hclk(hclk), .rst(rst), .start(start), .addr(BASE_ADDR + {24'b0, ofs}),
        .write(xfer_write), .wdata(wdata), .busy(busy), .rdata(rdata),
        .xfer_done(xfer_done), .bus(bus)
    );

    always_comb begin
        state_nx   = state;
        ofs        = OFS_TIMING;
        wdata      = '0;
        xfer_write = 1'b0;
        xfer_state = 1'b1;
        case (state)
            S_IDLE:      begin xfer_state = 1'b0; state_nx = req_valid ? S_WR_TIM : S_IDLE; end
            S_WR_TIM:    begin xfer_write = 1'b1; wdata = timing_q; state_nx = xfer_done ? S_WR_COL : state; end
            S_WR_COL:    begin xfer_write = 1'b1; ofs = OFS_COL; wdata = {16'b0, col_q}; state_nx = xfer_done ? S_WR_ROW : state; end
            S_WR_ROW:    begin xfer_write = 1'b1; ofs = OFS_ROW; wdata = {8'b0, row_q}; state_nx = xfer_done ? S_WR_CFG : state; end
            S_WR_CFG:    begin xfer_write = 1'b1; ofs = OFS_CFG; wdata = {29'b0, cfg_q}; state_nx = xfer_done ? S_WR_CMD : state; end
            S_WR_CMD:    begin xfer_write = 1'b1; ofs = OFS_CMD; wdata = {16'b0, cmd_q}; state_nx = xfer_done ? S_WAIT_DONE : state; end
            S_WAIT_DONE: begin xfer_state = 1'b0; state_nx = (done_rise || to_hit) ? S_RD_STAT : state; end
            // a timed-out operation has no valid ID, so skip straight to the response
            S_RD_STAT:   begin ofs = OFS_MFSM; state_nx = !xfer_done ? state : (cmd_q == CMD_READ_ID && !rsp_timeout) ? S_RD_ID0 : S_RESP; end
            S_RD_ID0:    begin ofs = OFS_ID0; state_nx = xfer_done ? S_RD_ID1 : state; end
            S_RD_ID1:    begin ofs = OFS_ID1; state_nx = xfer_done ? S_RESP : state; end
            S_RESP:      begin xfer_state = 1'b0; state_nx = rsp_ready ? S_IDLE : S_RESP; end
            default:     begin xfer_state = 1'b0; state_nx = S_IDLE; end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (rst) begin
            state       <= S_IDLE;
            timing_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            cfg_q       <= '0;
            cmd_q       <= '0;
            done_q      <= 1'b0;
            to_cnt      <= '0;
            rsp_status  <= '0;
            rsp_id      <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= done_i;
            to_cnt <= state == S_WAIT_DONE ? to_cnt + 1'b1 : '0;
            if (state == S_IDLE && req_valid) begin
                timing_q    <= req_timing;
                col_q       <= req_col;
                row_q       <= req_row;
                cfg_q       <= req_cfg;
                cmd_q       <= req_cmd;
                rsp_status  <= '0;
                rsp_id      <= '0;
                rsp_timeout <= 1'b0;
            end
            // a done edge coinciding with terminal count counts as success
            if (state == S_WAIT_DONE && !done_rise && to_hit) rsp_timeout <= 1'b1;
            if (xfer_done && state == S_RD_STAT) rsp_status <= rdata[7:0];
            if (xfer_done && state == S_RD_ID0) rsp_id[31:0] <= rdata;
            if (xfer_done && state == S_RD_ID1) rsp_id[47:32] <= rdata[15:0];
        end
    end
endmodule

// File: tb/tb_nand_cmd_master.sv
// tb_nand_cmd_master: directed checks of register programming, handshakes, timeout and reset abort
module tb_nand_cmd_master;
    import nand_ctrl_pkg::*;
    localparam logic [31:0] BASE = 32'h0000_0500;

    logic        hclk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, done_i = 1'b0, rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] req_timing = '0;
    logic [15:0] req_col = '0, req_cmd = '0;
    logic [23:0] req_row = '0;
    logic [2:0]  req_cfg = '0;
    logic [7:0]  rsp_status;
    logic [47:0] rsp_id;
    int vec = 0, miss = 0, n = 0;

    nand_cmd_master_if bus ();

    nand_cmd_master #(.BASE_ADDR(BASE), .CMD_READ_ID(16'h0090), .TO_W(4)) dut (
        .hclk(hclk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_timing(req_timing), .req_col(req_col), .req_row(req_row), .req_cfg(req_cfg),
        .req_cmd(req_cmd), .bus(bus), .done_i(done_i), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_id(rsp_id), .rsp_timeout(rsp_timeout)
    );

    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_nonseq(input string tag, output int cnt);
        cnt = 0;
        while (bus.htrans !== HTRANS_NONSEQ && cnt < 40) begin
            tick();
            cnt++;
        end
        chk({tag, "_start"}, 64'(cnt < 40), 64'd1);
    endtask

    task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [31:0] rd, output int cnt);
        wait_nonseq(tag, cnt);
        chk({tag, "_haddr"}, 64'(bus.haddr), 64'(a));
        chk({tag, "_hwrite"}, 64'(bus.hwrite), 64'(w));
        tick();
        chk({tag, "_data_htrans"}, 64'(bus.htrans), 64'(HTRANS_IDLE));
        if (w) chk({tag, "_hwdata"}, 64'(bus.hwdata), 64'(d));
        bus.hrdata = rd;
        tick();
    endtask

    task automatic send_req(input string tag, input logic [31:0] tim, input logic [15:0] col,
                            input logic [23:0] row, input logic [2:0] cfg, input logic [15:0] cmd);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        req_timing = tim; req_col = col; req_row = row; req_cfg = cfg; req_cmd = cmd;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic writes(input string tag, input logic [31:0] tim, input logic [15:0] col,
                          input logic [23:0] row, input logic [2:0] cfg, input logic [15:0] cmd);
        int c;
        xfer({tag, "_tim"}, BASE + 32'h00, 1'b1, tim, 32'h0, c);
        xfer({tag, "_col"}, BASE + 32'h04, 1'b1, {16'h0, col}, 32'h0, c);
        xfer({tag, "_row"}, BASE + 32'h08, 1'b1, {8'h0, row}, 32'h0, c);
        xfer({tag, "_cfg"}, BASE + 32'h0C, 1'b1, {29'h0, cfg}, 32'h0, c);
        xfer({tag, "_cmd"}, BASE + 32'h10, 1'b1, {16'h0, cmd}, 32'h0, c);
    endtask

    task automatic check_rsp(input string tag, input logic [7:0] st, input logic [47:0] id, input logic to);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_req_ready_busy"}, 64'(req_ready), 64'd0);
        chk({tag, "_status"}, 64'(rsp_status), 64'(st));
        chk({tag, "_id"}, 64'(rsp_id), 64'(id));
        chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(to));
        tick();
        chk({tag, "_rsp_held"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_status_held"}, 64'(rsp_status), 64'(st));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_clr"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_req_ready_back"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.hready = 1'b1;
        bus.hrdata = '0;
        tick();
        tick();
        chk("rst_htrans", 64'(bus.htrans), 64'(HTRANS_IDLE));
        chk("rst_hwrite", 64'(bus.hwrite), 64'd0);
        chk("rst_haddr", 64'(bus.haddr), 64'd0);
        chk("rst_hwdata", 64'(bus.hwdata), 64'd0);
        chk("rst_hsize", 64'(bus.hsize), 64'(3'b010));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_status", 64'(rsp_status), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        rst = 1'b0;
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        // 1: plain program command, done pulse, status read-back only
        send_req("t1", 32'h0010_0020, 16'h0123, 24'h01_2345, 3'b101, 16'h0060);
        writes("t1", 32'h0010_0020, 16'h0123, 24'h01_2345, 3'b101, 16'h0060);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        xfer("t1_stat", BASE + 32'h1C, 1'b0, 32'h0, 32'hABCD_1234, n);
        check_rsp("t1", 8'h34, 48'h0, 1'b0);

        // 2: READ-ID adds two ID reads
        send_req("t2", 32'h0003_0004, 16'h0000, 24'h00_0000, 3'b000, 16'h0090);
        writes("t2", 32'h0003_0004, 16'h0000, 24'h00_0000, 3'b000, 16'h0090);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        xfer("t2_stat", BASE + 32'h1C, 1'b0, 32'h0, 32'h5555_0081, n);
        xfer("t2_id0", BASE + 32'h14, 1'b0, 32'h0, 32'hDDCC_BBAA, n);
        xfer("t2_id1", BASE + 32'h18, 1'b0, 32'h0, 32'h0000_FFEE, n);
        check_rsp("t2", 8'h81, 48'hFFEE_DDCC_BBAA, 1'b0);

        // 3: wait states in address and data phases of the first write
        send_req("t3", 32'hCAFE_F00D, 16'h0A0B, 24'h0C_0D0E, 3'b010, 16'h0060);
        wait_nonseq("t3_tim", n);
        bus.hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_addr_hold_htrans", 64'(bus.htrans), 64'(HTRANS_NONSEQ));
            chk("t3_addr_hold_haddr", 64'(bus.haddr), 64'(BASE));
        end
        bus.hready = 1'b1;
        tick();
        chk("t3_data_htrans", 64'(bus.htrans), 64'(HTRANS_IDLE));
        bus.hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_data_hold_htrans", 64'(bus.htrans), 64'(HTRANS_IDLE));
            chk("t3_data_hold_hwdata", 64'(bus.hwdata), 64'h0000_0000_CAFE_F00D);
        end
        bus.hready = 1'b1;
        tick();
        xfer("t3_col", BASE + 32'h04, 1'b1, 32'h0000_0A0B, 32'h0, n);
        xfer("t3_row", BASE + 32'h08, 1'b1, 32'h000C_0D0E, 32'h0, n);
        xfer("t3_cfg", BASE + 32'h0C, 1'b1, 32'h0000_0002, 32'h0, n);
        xfer("t3_cmd", BASE + 32'h10, 1'b1, 32'h0000_0060, 32'h0, n);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        xfer("t3_stat", BASE + 32'h1C, 1'b0, 32'h0, 32'h0000_00C3, n);
        check_rsp("t3", 8'hC3, 48'h0, 1'b0);

        // 4: done never rises; READ-ID command must still skip the ID reads
        send_req("t4", 32'h1111_2222, 16'h0001, 24'h00_0002, 3'b001, 16'h0090);
        writes("t4", 32'h1111_2222, 16'h0001, 24'h00_0002, 3'b001, 16'h0090);
        xfer("t4_stat", BASE + 32'h1C, 1'b0, 32'h0, 32'h0000_00E1, n);
        chk("t4_wait_len", 64'(n >= 15 && n <= 18), 64'd1);
        check_rsp("t4", 8'hE1, 48'h0, 1'b1);

        // 5: done already high on entry is not a completion
        done_i = 1'b1;
        send_req("t5", 32'h0000_0001, 16'h0002, 24'h00_0003, 3'b100, 16'h0060);
        writes("t5", 32'h0000_0001, 16'h0002, 24'h00_0003, 3'b100, 16'h0060);
        xfer("t5_stat", BASE + 32'h1C, 1'b0, 32'h0, 32'h0000_0042, n);
        chk("t5_wait_len", 64'(n >= 15 && n <= 18), 64'd1);
        check_rsp("t5", 8'h42, 48'h0, 1'b1);
        done_i = 1'b0;

        // 6: reset in the middle of the row write aborts cleanly
        send_req("t6", 32'h0102_0304, 16'h0506, 24'h07_0809, 3'b011, 16'h0060);
        xfer("t6_tim", BASE + 32'h00, 1'b1, 32'h0102_0304, 32'h0, n);
        xfer("t6_col", BASE + 32'h04, 1'b1, 32'h0000_0506, 32'h0, n);
        wait_nonseq("t6_row", n);
        chk("t6_row_haddr", 64'(bus.haddr), 64'(BASE + 32'h08));
        rst = 1'b1;
        tick();
        chk("t6_abort_htrans", 64'(bus.htrans), 64'(HTRANS_IDLE));
        chk("t6_abort_req_ready", 64'(req_ready), 64'd1);
        chk("t6_abort_rsp_valid", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        tick();
        send_req("t6b", 32'h0A0A_0B0B, 16'h0C0C, 24'h0D_0D0D, 3'b110, 16'h0030);
        writes("t6b", 32'h0A0A_0B0B, 16'h0C0C, 24'h0D_0D0D, 3'b110, 16'h0030);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        xfer("t6b_stat", BASE + 32'h1C, 1'b0, 32'h0, 32'h0000_0007, n);
        check_rsp("t6b", 8'h07, 48'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
